// File: rtl/cordic_phase_front.sv
// Phase front-end for an iterative cordic sin/cos core: folds a full-turn phase into the
// first quadrant, runs the core handshake with a timeout, and unfolds the result.
module cordic_phase_front #(
  parameter int W       = 12,
  parameter int PW      = 12,
  parameter int TIMEOUT = 256
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          phase_valid,
  output logic          phase_ready,
  input  logic [PW-1:0] phase_in,
  output logic          cordic_start,
  output logic [W-1:0]  cordic_angle,
  input  logic          cordic_ready,
  input  logic [W-1:0]  cordic_sin,
  input  logic [W-1:0]  cordic_cos,
  output logic          res_valid,
  input  logic          res_ack,
  output logic [W-1:0]  res_sin,
  output logic [W-1:0]  res_cos,
  output logic [1:0]    res_quad,
  output logic          res_err
);

  localparam int RW = PW - 2;
  localparam int SW = RW + 11;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CONV  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] BUSY  = 3'd3;
  localparam logic [2:0] FIX   = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;

  logic [2:0]    state_r;
  logic [1:0]    q_r;
  logic [RW-1:0] r_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  s_r;
  logic [W-1:0]  c_r;
  logic [W-1:0]  angle_r;
  logic          start_r;
  logic          phase_ready_r;
  logic          res_valid_r;
  logic          res_err_r;
  logic [W-1:0]  res_sin_r;
  logic [W-1:0]  res_cos_r;
  logic [1:0]    res_quad_r;

  logic [SW-1:0] sum_s;
  logic [W-1:0]  angle_s;
  logic [W-1:0]  fix_sin_s;
  logic [W-1:0]  fix_cos_s;
  logic          timeout_s;

  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Angle scaling r * 1608/1024 with rounding, shift-add only (1608 = 1024+512+64+8).
  always_comb begin
    sum_s   = (SW'(r_r) << 10) + (SW'(r_r) << 9) + (SW'(r_r) << 6) + (SW'(r_r) << 3)
              + SW'(11'd512);
    angle_s = W'(sum_s >> 10);
  end

  // Quadrant unfolding of the captured first-quadrant core result.
  always_comb begin
    fix_sin_s = s_r;
    fix_cos_s = c_r;
    case (q_r)
      2'd0: begin fix_sin_s = s_r;      fix_cos_s = c_r;      end
      2'd1: begin fix_sin_s = c_r;      fix_cos_s = neg(s_r); end
      2'd2: begin fix_sin_s = neg(s_r); fix_cos_s = neg(c_r); end
      2'd3: begin fix_sin_s = neg(c_r); fix_cos_s = s_r;      end
      default: begin fix_sin_s = s_r;   fix_cos_s = c_r;      end
    endcase
  end

  // The counter has just reached TIMEOUT-1 once this cycle's increment lands.
  assign timeout_s = (cnt_r == CW'(TIMEOUT - 2));

  // Sequencer: phase intake, core handshake with timeout, result hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      q_r           <= 2'd0;
      r_r           <= '0;
      cnt_r         <= '0;
      s_r           <= '0;
      c_r           <= '0;
      angle_r       <= '0;
      start_r       <= 1'b0;
      phase_ready_r <= 1'b1;
      res_valid_r   <= 1'b0;
      res_err_r     <= 1'b0;
      res_sin_r     <= '0;
      res_cos_r     <= '0;
      res_quad_r    <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (phase_valid) begin
            q_r           <= phase_in[PW-1 -: 2];
            r_r           <= phase_in[RW-1:0];
            phase_ready_r <= 1'b0;
            state_r       <= CONV;
          end
        end
        CONV: begin
          angle_r <= angle_s;
          cnt_r   <= '0;
          start_r <= 1'b1;
          state_r <= ISSUE;
        end
        ISSUE, BUSY: begin
          cnt_r <= cnt_r + CW'(1'b1);
          // In ISSUE a stale ready from the previous operation must fall first.
          if (state_r == BUSY && cordic_ready) begin
            s_r     <= cordic_sin;
            c_r     <= cordic_cos;
            start_r <= 1'b0;
            state_r <= FIX;
          end else if (timeout_s) begin
            start_r     <= 1'b0;
            res_sin_r   <= '0;
            res_cos_r   <= '0;
            res_err_r   <= 1'b1;
            res_quad_r  <= q_r;
            res_valid_r <= 1'b1;
            state_r     <= HOLD;
          end else if (state_r == ISSUE && !cordic_ready) begin
            state_r <= BUSY;
          end
        end
        FIX: begin
          res_sin_r   <= fix_sin_s;
          res_cos_r   <= fix_cos_s;
          res_quad_r  <= q_r;
          res_err_r   <= 1'b0;
          res_valid_r <= 1'b1;
          state_r     <= HOLD;
        end
        HOLD: begin
          if (res_ack) begin
            res_valid_r   <= 1'b0;
            phase_ready_r <= 1'b1;
            state_r       <= IDLE;
          end
        end
        default: begin
          start_r       <= 1'b0;
          res_valid_r   <= 1'b0;
          phase_ready_r <= 1'b1;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign phase_ready  = phase_ready_r;
  assign cordic_start = start_r;
  assign cordic_angle = angle_r;
  assign res_valid    = res_valid_r;
  assign res_sin      = res_sin_r;
  assign res_cos      = res_cos_r;
  assign res_quad     = res_quad_r;
  assign res_err      = res_err_r;

endmodule

// File: tb/tb_cordic_phase_front.sv
// Directed bench for cordic_phase_front with a programmable stub cordic core.
module tb_cordic_phase_front;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        phase_valid = 1'b0;
  logic        phase_ready;
  logic [11:0] phase_in = 12'd0;
  logic        cordic_start;
  logic [11:0] cordic_angle;
  logic        cordic_ready = 1'b0;
  logic [11:0] cordic_sin = 12'd0;
  logic [11:0] cordic_cos = 12'd0;
  logic        res_valid;
  logic        res_ack = 1'b0;
  logic [11:0] res_sin;
  logic [11:0] res_cos;
  logic [1:0]  res_quad;
  logic        res_err;

  cordic_phase_front #(.W(12), .PW(12), .TIMEOUT(256)) dut (
    .clock(clock), .reset(reset),
    .phase_valid(phase_valid), .phase_ready(phase_ready), .phase_in(phase_in),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle), .cordic_ready(cordic_ready),
    .cordic_sin(cordic_sin), .cordic_cos(cordic_cos),
    .res_valid(res_valid), .res_ack(res_ack), .res_sin(res_sin), .res_cos(res_cos),
    .res_quad(res_quad), .res_err(res_err)
  );

  always #5 clock = ~clock;

  // Stub core settings, written by the stimulus process only.
  logic [11:0] pend_sin = 12'd0;
  logic [11:0] pend_cos = 12'd0;
  int          stub_lat = 2;
  int          stub_drop = 1;
  bit          stub_never = 1'b0;
  bit          st_on = 1'b0;
  int          st_cnt = 0;

  // Stub: ready falls stub_drop cycles after start, rises stub_lat cycles after that.
  always @(negedge clock) begin
    if (!cordic_start) begin
      st_on  = 1'b0;
      st_cnt = 0;
    end else begin
      if (!st_on) begin
        st_on  = 1'b1;
        st_cnt = 0;
      end
      st_cnt = st_cnt + 1;
      if (st_cnt == stub_drop) cordic_ready = 1'b0;
      if (!stub_never && st_cnt == stub_drop + stub_lat) begin
        cordic_sin   = pend_sin;
        cordic_cos   = pend_cos;
        cordic_ready = 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [11:0] phase;
    logic [11:0] s;
    logic [11:0] c;
    int          lat;
    int          drop;
    logic [11:0] exp_angle;
    logic [11:0] exp_sin;
    logic [11:0] exp_cos;
    logic [1:0]  exp_quad;
  } vec_t;

  vec_t vecs[8];

  task automatic run_op(input vec_t v, input string tag);
    int k;
    pend_sin  = v.s;
    pend_cos  = v.c;
    stub_lat  = v.lat;
    stub_drop = v.drop;
    phase_in  = v.phase;
    phase_valid = 1'b1;
    k = 0;
    while (!phase_ready && k < 50) begin tick(); k++; end
    check({tag, " ready_wait"}, 32'(k < 50), 32'd1);
    tick();
    phase_valid = 1'b0;
    tick();
    check({tag, " angle"}, 32'(cordic_angle), 32'(v.exp_angle));
    check({tag, " start"}, 32'(cordic_start), 32'd1);
    k = 0;
    while (cordic_start && k < 600) begin tick(); k++; end
    check({tag, " core_wait"}, 32'(k < 600), 32'd1);
    check({tag, " valid_fix"}, 32'(res_valid), 32'd0);
    tick();
    check({tag, " valid"}, 32'(res_valid), 32'd1);
    check({tag, " sin"}, 32'(res_sin), 32'(v.exp_sin));
    check({tag, " cos"}, 32'(res_cos), 32'(v.exp_cos));
    check({tag, " quad"}, 32'(res_quad), 32'(v.exp_quad));
    check({tag, " err"}, 32'(res_err), 32'd0);
    check({tag, " pready_hold"}, 32'(phase_ready), 32'd0);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check({tag, " valid_ack"}, 32'(res_valid), 32'd0);
    check({tag, " pready_ack"}, 32'(phase_ready), 32'd1);
    check({tag, " sin_kept"}, 32'(res_sin), 32'(v.exp_sin));
  endtask

  initial begin
    int k;
    vecs[0] = '{12'h000, 12'd300, 12'd900, 2, 1, 12'd0,    12'h12C, 12'h384, 2'd0};
    vecs[1] = '{12'h400, 12'd300, 12'd900, 3, 1, 12'd0,    12'h384, 12'hED4, 2'd1};
    vecs[2] = '{12'hA00, 12'd724, 12'd724, 2, 1, 12'd804,  12'hD2C, 12'hD2C, 2'd2};
    vecs[3] = '{12'hE00, 12'd724, 12'd724, 4, 1, 12'd804,  12'hD2C, 12'h2D4, 2'd3};
    vecs[4] = '{12'h3FF, 12'hF9C, 12'h032, 2, 4, 12'd1606, 12'hF9C, 12'h032, 2'd0};
    vecs[5] = '{12'hFFF, 12'h100, 12'hF00, 5, 1, 12'd1606, 12'h100, 12'h100, 2'd3};
    vecs[6] = '{12'h7FF, 12'h7FF, 12'h801, 2, 2, 12'd1606, 12'h801, 12'h801, 2'd1};
    vecs[7] = '{12'h555, 12'd10,  12'd20,  3, 1, 12'd535,  12'h014, 12'hFF6, 2'd1};

    // Reset values
    tick(); tick();
    check("rst phase_ready", 32'(phase_ready), 32'd1);
    check("rst start", 32'(cordic_start), 32'd0);
    check("rst valid", 32'(res_valid), 32'd0);
    check("rst err", 32'(res_err), 32'd0);
    check("rst angle", 32'(cordic_angle), 32'd0);
    check("rst sin", 32'(res_sin), 32'd0);
    check("rst cos", 32'(res_cos), 32'd0);
    check("rst quad", 32'(res_quad), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with res_ack tied high
    res_ack = 1'b1;
    pend_sin = 12'd1; pend_cos = 12'd2; stub_lat = 2; stub_drop = 1;
    phase_in = 12'h000; phase_valid = 1'b1;
    k = 0;
    while (!res_valid && k < 100) begin tick(); k++; end
    check("b2b1 seen", 32'(res_valid), 32'd1);
    check("b2b1 sin", 32'(res_sin), 32'h001);
    check("b2b1 cos", 32'(res_cos), 32'h002);
    check("b2b1 pready", 32'(phase_ready), 32'd0);
    pend_sin = 12'd5; pend_cos = 12'd6; phase_in = 12'h800;
    tick();
    check("b2b1 valid_drop", 32'(res_valid), 32'd0);
    k = 0;
    while (!res_valid && k < 100) begin tick(); k++; end
    phase_valid = 1'b0;
    check("b2b2 seen", 32'(res_valid), 32'd1);
    check("b2b2 sin", 32'(res_sin), 32'hFFB);
    check("b2b2 cos", 32'(res_cos), 32'hFFA);
    check("b2b2 quad", 32'(res_quad), 32'd2);
    tick();
    res_ack = 1'b0;
    check("b2b2 idle", 32'(phase_ready), 32'd1);

    // Timeout: core never answers
    stub_never = 1'b1; stub_drop = 1;
    phase_in = 12'h600; phase_valid = 1'b1;
    tick(); phase_valid = 1'b0;
    tick();
    check("to angle", 32'(cordic_angle), 32'd804);
    k = 0;
    while (cordic_start && k < 400) begin tick(); k++; end
    check("to start_cycles", 32'(k), 32'd255);
    check("to valid", 32'(res_valid), 32'd1);
    check("to err", 32'(res_err), 32'd1);
    check("to sin", 32'(res_sin), 32'd0);
    check("to cos", 32'(res_cos), 32'd0);
    check("to quad", 32'(res_quad), 32'd1);
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    stub_never = 1'b0;
    run_op(vecs[1], "after_to");

    // Asynchronous reset in the middle of BUSY
    pend_sin = 12'd7; pend_cos = 12'd8; stub_lat = 40; stub_drop = 1;
    phase_in = 12'h123; phase_valid = 1'b1;
    tick(); phase_valid = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    check("mid start_before", 32'(cordic_start), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid start", 32'(cordic_start), 32'd0);
    check("mid valid", 32'(res_valid), 32'd0);
    check("mid pready", 32'(phase_ready), 32'd1);
    check("mid angle", 32'(cordic_angle), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("post pready", 32'(phase_ready), 32'd1);
    run_op(vecs[4], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
